// File: rtl/vga_text_render.sv
// Text-mode pixel renderer: maps VGA coordinates to character cells, fetches the
// code from the text buffer and the glyph from char_set, and emits a 4-stage registered pixel.
module vga_text_render #(
  parameter int          COLS  = 40,
  parameter int          ROWS  = 12,
  parameter int          SCALE = 2,
  parameter int          X0    = 40,
  parameter int          Y0    = 48,
  parameter logic [11:0] FG    = 12'hFFF,
  parameter logic [11:0] BG    = 12'h000,
  localparam int         AW    = $clog2(COLS * ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    hcnt,
  input  logic [9:0]    vcnt,
  input  logic          de_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [AW-1:0] buf_addr,
  input  logic [5:0]    buf_data,
  output logic [5:0]    char_code,
  input  logic [7:0]    col0,
  input  logic [7:0]    col1,
  input  logic [7:0]    col2,
  input  logic [7:0]    col3,
  input  logic [7:0]    col4,
  input  logic [7:0]    col5,
  input  logic [7:0]    col6,
  output logic [11:0]   rgb,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          de_out
);

  localparam int XEND = X0 + COLS * 7 * SCALE;
  localparam int YEND = Y0 + ROWS * 8 * SCALE;
  localparam int SW   = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [9:0]    X0C   = 10'(X0);
  localparam logic [9:0]    XENDC = 10'(XEND);
  localparam logic [9:0]    Y0C   = 10'(Y0);
  localparam logic [9:0]    YENDC = 10'(YEND);
  localparam logic [SW-1:0] SMAX  = SW'(SCALE - 1);
  localparam logic [SW-1:0] SONE  = SW'(1);
  localparam logic [AW-1:0] CMAX  = AW'(COLS - 1);
  localparam logic [AW-1:0] COLSC = AW'(COLS);
  localparam logic [AW-1:0] BMAX  = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] AONE  = AW'(1);
  localparam logic [5:0]    SPACE = 6'h3E;

  logic          hInRange, vInRange, inWin;
  logic [9:0]    jTarget;

  logic [SW-1:0] sx_q, sx_d, sxNow;
  logic [2:0]    gx_q, gx_d, gxNow;
  logic [AW-1:0] cc_q, cc_d, ccNow;
  logic [SW-1:0] sy_q, sy_d;
  logic [2:0]    gy_q, gy_d;
  logic [AW-1:0] base_q, base_d;
  logic [9:0]    j_q, j_d;

  logic [AW-1:0] addr_q, addr_d;
  logic          inWin1_q, inWin2_q, inWin3_q;
  logic [2:0]    gx1_q, gx2_q, gx3_q;
  logic [2:0]    gy1_q, gy2_q, gy3_q;
  logic [3:0]    de_q, hs_q, vs_q;
  logic [11:0]   rgb_q, rgb_d;
  logic [7:0]    colSel;
  logic          litBit;

  assign hInRange = (hcnt >= X0C) && (hcnt < XENDC);
  assign vInRange = (vcnt >= Y0C) && (vcnt < YENDC);
  assign inWin    = hInRange && vInRange;
  assign jTarget  = vcnt - Y0C;

  // Vertical position of the current line. j_q tracks the line index the counters
  // represent, so after a reset or a coordinate jump they step once per clock until
  // they catch up; in normal scanning that is exactly one step at the start of each line.
  always_comb begin
    sy_d   = sy_q;
    gy_d   = gy_q;
    base_d = base_q;
    j_d    = j_q;
    if (vcnt == Y0C || (vInRange && j_q > jTarget)) begin
      sy_d   = '0;
      gy_d   = '0;
      base_d = '0;
      j_d    = '0;
    end else if (vInRange && j_q < jTarget) begin
      j_d = j_q + 10'd1;
      if (sy_q == SMAX) begin
        sy_d = '0;
        if (gy_q == 3'd7) begin
          gy_d   = '0;
          base_d = (base_q == BMAX) ? '0 : base_q + COLSC;
        end else begin
          gy_d = gy_q + 3'd1;
        end
      end else begin
        sy_d = sy_q + SONE;
      end
    end
  end

  // Horizontal position: the first window pixel of every line restarts at zero,
  // the registers then hold the position of the following pixel.
  always_comb begin
    sxNow = (hcnt == X0C) ? '0 : sx_q;
    gxNow = (hcnt == X0C) ? '0 : gx_q;
    ccNow = (hcnt == X0C) ? '0 : cc_q;
    sx_d  = sx_q;
    gx_d  = gx_q;
    cc_d  = cc_q;
    if (inWin) begin
      sx_d = sxNow;
      gx_d = gxNow;
      cc_d = ccNow;
      if (sxNow == SMAX) begin
        sx_d = '0;
        if (gxNow == 3'd6) begin
          gx_d = '0;
          cc_d = (ccNow == CMAX) ? '0 : ccNow + AONE;
        end else begin
          gx_d = gxNow + 3'd1;
        end
      end else begin
        sx_d = sxNow + SONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx_q   <= '0;
      gx_q   <= '0;
      cc_q   <= '0;
      sy_q   <= '0;
      gy_q   <= '0;
      base_q <= '0;
      j_q    <= '0;
    end else begin
      sx_q   <= sx_d;
      gx_q   <= gx_d;
      cc_q   <= cc_d;
      sy_q   <= sy_d;
      gy_q   <= gy_d;
      base_q <= base_d;
      j_q    <= j_d;
    end
  end

  assign addr_d = inWin ? (base_d + ccNow) : addr_q;

  always_comb begin
    case (gx3_q)
      3'd0:    colSel = col0;
      3'd1:    colSel = col1;
      3'd2:    colSel = col2;
      3'd3:    colSel = col3;
      3'd4:    colSel = col4;
      3'd5:    colSel = col5;
      3'd6:    colSel = col6;
      default: colSel = 8'h00;
    endcase
  end

  assign litBit = colSel[gy3_q];
  assign rgb_d  = !de_q[2] ? 12'h000 : ((inWin3_q && litBit) ? FG : BG);

  // Pipeline: address (1), character code (2), glyph columns (3), pixel (4).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      inWin1_q <= 1'b0;
      inWin2_q <= 1'b0;
      inWin3_q <= 1'b0;
      gx1_q    <= '0;
      gx2_q    <= '0;
      gx3_q    <= '0;
      gy1_q    <= '0;
      gy2_q    <= '0;
      gy3_q    <= '0;
      de_q     <= 4'h0;
      hs_q     <= 4'hF;
      vs_q     <= 4'hF;
      rgb_q    <= 12'h000;
    end else begin
      addr_q   <= addr_d;
      inWin1_q <= inWin;
      inWin2_q <= inWin1_q;
      inWin3_q <= inWin2_q;
      gx1_q    <= gxNow;
      gx2_q    <= gx1_q;
      gx3_q    <= gx2_q;
      gy1_q    <= gy_d;
      gy2_q    <= gy1_q;
      gy3_q    <= gy2_q;
      de_q     <= {de_q[2:0], de_in};
      hs_q     <= {hs_q[2:0], hsync_in};
      vs_q     <= {vs_q[2:0], vsync_in};
      rgb_q    <= rgb_d;
    end
  end

  assign buf_addr  = addr_q;
  assign char_code = inWin2_q ? buf_data : SPACE;
  assign rgb       = rgb_q;
  assign de_out    = de_q[3];
  assign hsync_out = hs_q[3];
  assign vsync_out = vs_q[3];

endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render with a behavioural text RAM and glyph ROM;
// expected values are worked out by hand from the default window geometry.
module tb_vga_text_render;

  localparam int AW = 9;

  logic          clk;
  logic          rst;
  logic [9:0]    hcnt, vcnt;
  logic          de_in, hsync_in, vsync_in;
  logic [AW-1:0] buf_addr;
  logic [5:0]    buf_data, char_code;
  logic [7:0]    col0, col1, col2, col3, col4, col5, col6;
  logic [11:0]   rgb;
  logic          hsync_out, vsync_out, de_out;

  int            passCount = 0;
  int            checkCount = 0;
  int            curH, curV;
  logic          deIn, hsIn, vsIn;
  logic [5:0]    textMem [0:479];
  logic [11:0]   dePat, hsPat, vsPat;

  vga_text_render dut (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .buf_addr(buf_addr), .buf_data(buf_data), .char_code(char_code),
    .col0(col0), .col1(col1), .col2(col2), .col3(col3),
    .col4(col4), .col5(col5), .col6(col6),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyphs packed col6..col0; 0x15 "L", 0x24 "/", 0x01 solid block.
  function automatic logic [55:0] glyph(input logic [5:0] code);
    case (code)
      6'h15:   glyph = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h00};
      6'h24:   glyph = {8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      6'h01:   glyph = {7{8'hFF}};
      default: glyph = 56'h0;
    endcase
  endfunction

  always @(posedge clk) buf_data <= textMem[buf_addr];
  always @(posedge clk) {col6, col5, col4, col3, col2, col1, col0} <= glyph(char_code);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int h, input int v);
    hcnt     = 10'(h);
    vcnt     = 10'(v);
    de_in    = deIn;
    hsync_in = hsIn;
    vsync_in = vsIn;
    curH     = h;
    curV     = v;
    @(posedge clk);
    #1;
  endtask

  task automatic scanLine(input int v, input int hFrom, input int hTo);
    for (int h = hFrom; h <= hTo; h++) applyStimulus(h, v);
  endtask

  task automatic walkTo(input int x, input int y);
    for (int v = 48; v < y; v++) applyStimulus(0, v);
    scanLine(y, 0, x);
  endtask

  task automatic stepOn();
    applyStimulus(curH + 1, curV);
  endtask

  task automatic checkPipe(input string tag, input bit chkAddr, input int expAddr,
                           input logic [5:0] expCode, input logic [11:0] expRgb);
    if (chkAddr) checkOutput({tag, ".addr"}, 32'(buf_addr), 32'(expAddr));
    stepOn();
    checkOutput({tag, ".code"}, 32'(char_code), 32'(expCode));
    stepOn();
    stepOn();
    checkOutput({tag, ".rgb"}, 32'(rgb), 32'(expRgb));
  endtask

  task automatic probe(input string tag, input int x, input int y, input bit chkAddr,
                       input int expAddr, input logic [5:0] expCode, input logic [11:0] expRgb);
    walkTo(x, y);
    checkPipe(tag, chkAddr, expAddr, expCode, expRgb);
  endtask

  initial begin
    for (int i = 0; i < 480; i++) textMem[i] = 6'h00;
    textMem[0]   = 6'h15;
    textMem[39]  = 6'h15;
    textMem[120] = 6'h15;
    textMem[125] = 6'h24;
    textMem[138] = 6'h01;
    for (int i = 440; i < 479; i++) textMem[i] = 6'h01;
    textMem[479] = 6'h15;

    deIn = 1'b1; hsIn = 1'b0; vsIn = 1'b0;
    rst = 1'b1;
    hcnt = 10'd0; vcnt = 10'd0; de_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    #12;
    checkOutput("reset.rgb", 32'(rgb), 32'h000);
    checkOutput("reset.de", 32'(de_out), 32'd0);
    checkOutput("reset.hs", 32'(hsync_out), 32'd1);
    checkOutput("reset.vs", 32'(vsync_out), 32'd1);
    checkOutput("reset.addr", 32'(buf_addr), 32'd0);
    checkOutput("reset.code", 32'(char_code), 32'h3E);
    hsIn = 1'b1; vsIn = 1'b1;
    rst = 1'b0;

    probe("L_40_48", 40, 48, 1'b1, 0, 6'h15, 12'h000);
    probe("L_42_48", 42, 48, 1'b1, 0, 6'h15, 12'hFFF);
    probe("L_44_48", 44, 48, 1'b1, 0, 6'h15, 12'h000);
    probe("L_44_62", 44, 62, 1'b1, 0, 6'h15, 12'hFFF);
    probe("addr125", 110, 96, 1'b1, 125, 6'h24, 12'h000);
    probe("addr479", 599, 239, 1'b1, 479, 6'h15, 12'hFFF);

    textMem[0] = 6'h24;
    probe("slash_40_62", 40, 62, 1'b1, 0, 6'h24, 12'hFFF);
    probe("slash_40_48", 40, 48, 1'b1, 0, 6'h24, 12'h000);

    probe("edge39", 39, 48, 1'b0, 0, 6'h3E, 12'h000);
    probe("edge600", 600, 48, 1'b1, 39, 6'h3E, 12'h000);

    walkTo(3, 240);
    for (int h = 4; h < 800; h++) begin
      applyStimulus(h, 240);
      checkOutput("line240", 32'({rgb, char_code}), 32'({12'h000, 6'h3E}));
    end

    textMem[0] = 6'h15;
    deIn = 1'b0;
    probe("deOff", 42, 48, 1'b1, 0, 6'h15, 12'h000);
    checkOutput("deOff.de", 32'(de_out), 32'd0);
    deIn = 1'b1;

    dePat = 12'b0110_1001_1101;
    hsPat = 12'b1011_0011_1000;
    vsPat = 12'b0101_1100_0110;
    for (int i = 0; i < 12; i++) begin
      deIn = dePat[i]; hsIn = hsPat[i]; vsIn = vsPat[i];
      applyStimulus(700 + i, 300);
      if (i >= 3) begin
        checkOutput("sync.de", 32'(de_out), 32'(dePat[i-3]));
        checkOutput("sync.hs", 32'(hsync_out), 32'(hsPat[i-3]));
        checkOutput("sync.vs", 32'(vsync_out), 32'(vsPat[i-3]));
      end
    end
    deIn = 1'b1; hsIn = 1'b0; vsIn = 1'b0;

    walkTo(300, 100);
    checkOutput("preRst.rgb", 32'(rgb), 32'hFFF);
    checkOutput("preRst.de", 32'(de_out), 32'd1);
    checkOutput("preRst.hs", 32'(hsync_out), 32'd0);
    checkOutput("preRst.addr", 32'(buf_addr), 32'd138);
    rst = 1'b1;
    #1;
    checkOutput("midRst.rgb", 32'(rgb), 32'h000);
    checkOutput("midRst.de", 32'(de_out), 32'd0);
    checkOutput("midRst.hs", 32'(hsync_out), 32'd1);
    checkOutput("midRst.vs", 32'(vsync_out), 32'd1);
    checkOutput("midRst.addr", 32'(buf_addr), 32'd0);
    rst = 1'b0;
    hsIn = 1'b1; vsIn = 1'b1;
    scanLine(100, 301, 799);
    scanLine(101, 0, 42);
    checkPipe("rstRecover", 1'b1, 120, 6'h15, 12'hFFF);
    checkOutput("rstRecover.de", 32'(de_out), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
